elevator_sequencer: RTL and testbench

- Sequential controller for the 3-floor single-car elevator.
- Latches hall calls (up/down per floor) and car calls (in per floor) into pending registers.
- Holds car position, door and direction state, and times door dwell and travel.
- Serves requests in SCAN order (continue in the current direction while requests lie ahead) and clears each request when the door opens for it.

---
 rtl/elevator_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_elevator_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/elevator_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : elevator_sequencer
// Purpose  : Sequential controller for a 3-floor single-car elevator. Latches
//            hall/car calls, tracks car position, door and direction, times
//            door dwell and travel, and serves calls in SCAN order.
// Ports    : clk, reset_n (async active-low)
//            button_up/button_down/button_in [2:0] : call buttons per floor
//            floor[1:0], half                      : car position
//            door_open, dir[1:0]                   : door / travel direction
//            pending_up/down/in [2:0]              : latched calls
//            busy                                  : not idle
// Revision : 1.0 - initial release
// ============================================================================
module elevator_sequencer #(
   parameter int DOOR_CYCLES   = 4,
   parameter int TRAVEL_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] button_up,
   input  logic [2:0] button_down,
   input  logic [2:0] button_in,
   output logic [1:0] floor,
   output logic       half,
   output logic       door_open,
   output logic [1:0] dir,
   output logic [2:0] pending_up,
   output logic [2:0] pending_down,
   output logic [2:0] pending_in,
   output logic       busy
);

   localparam int c_DOOR_W   = $clog2(DOOR_CYCLES + 1);
   localparam int c_TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
   localparam logic [c_DOOR_W-1:0]   c_DOOR_LOAD   = c_DOOR_W'(DOOR_CYCLES);
   localparam logic [c_DOOR_W-1:0]   c_DOOR_ONE    = c_DOOR_W'(1);
   localparam logic [c_TRAVEL_W-1:0] c_TRAVEL_LOAD = c_TRAVEL_W'(TRAVEL_CYCLES);
   localparam logic [c_TRAVEL_W-1:0] c_TRAVEL_ONE  = c_TRAVEL_W'(1);

   localparam logic [1:0] c_DIR_STOP = 2'b00;
   localparam logic [1:0] c_DIR_UP   = 2'b01;
   localparam logic [1:0] c_DIR_DOWN = 2'b10;

   typedef enum logic [1:0] {
      ST_AT_FLOOR = 2'd0,
      ST_OPEN     = 2'd1,
      ST_MOVE     = 2'd2
   } state_t;

   state_t                r_state;
   logic [1:0]            r_floor;
   logic                  r_half;
   logic                  r_door_open;
   logic [1:0]            r_dir;
   logic [2:0]            r_pend_up;
   logic [2:0]            r_pend_down;
   logic [2:0]            r_pend_in;
   logic [c_DOOR_W-1:0]   r_door_timer;
   logic [c_TRAVEL_W-1:0] r_travel_timer;

   logic [2:0] w_btn_up, w_btn_down;
   logic [2:0] w_req, w_here;
   logic       w_above, w_below, w_ahead;
   logic [1:0] w_eff_dir;
   logic       w_stop;
   logic [2:0] w_clr_up, w_clr_down;
   logic [2:0] w_hold_up, w_hold_down, w_hold_in;
   logic       w_hold;
   logic [2:0] w_set_up, w_set_down, w_set_in;

   // No up call exists at the top floor, no down call at the bottom floor.
   assign w_btn_up   = button_up   & 3'b011;
   assign w_btn_down = button_down & 3'b110;

   assign w_req  = r_pend_in | r_pend_up | r_pend_down;
   assign w_here = 3'b001 << r_floor;

   always_comb begin
      w_above = 1'b0;
      w_below = 1'b0;
      case (r_floor)
         2'd0: w_above = |w_req[2:1];
         2'd1: begin
            w_above = w_req[2];
            w_below = w_req[0];
         end
         2'd2: w_below = |w_req[1:0];
         default: ;
      endcase
   end

   assign w_ahead   = (r_dir == c_DIR_UP)   ? w_above :
                      (r_dir == c_DIR_DOWN) ? w_below : 1'b0;
   assign w_eff_dir = w_ahead ? r_dir : c_DIR_STOP;

   // A hall call is served only if the car will not be leaving against it.
   assign w_clr_up   = (w_eff_dir != c_DIR_DOWN) ? w_here : 3'b000;
   assign w_clr_down = (w_eff_dir != c_DIR_UP)   ? w_here : 3'b000;
   assign w_stop     = |((r_pend_in & w_here) | (r_pend_up & w_clr_up) |
                         (r_pend_down & w_clr_down));

   // While the door is open, a press that would be served here keeps the
   // door open instead of being latched.
   assign w_hold_in   = button_in & w_here;
   assign w_hold_up   = (r_dir != c_DIR_DOWN) ? (w_btn_up & w_here)   : 3'b000;
   assign w_hold_down = (r_dir != c_DIR_UP)   ? (w_btn_down & w_here) : 3'b000;
   assign w_hold      = (r_state == ST_OPEN) &&
                        (|(w_hold_in | w_hold_up | w_hold_down));

   assign w_set_in   = (r_state == ST_OPEN) ? (button_in  & ~w_hold_in)   : button_in;
   assign w_set_up   = (r_state == ST_OPEN) ? (w_btn_up   & ~w_hold_up)   : w_btn_up;
   assign w_set_down = (r_state == ST_OPEN) ? (w_btn_down & ~w_hold_down) : w_btn_down;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_AT_FLOOR;
         r_floor        <= 2'd0;
         r_half         <= 1'b0;
         r_door_open    <= 1'b0;
         r_dir          <= c_DIR_STOP;
         r_pend_up      <= 3'b000;
         r_pend_down    <= 3'b000;
         r_pend_in      <= 3'b000;
         r_door_timer   <= '0;
         r_travel_timer <= '0;
      end else begin
         r_pend_up   <= r_pend_up   | w_set_up;
         r_pend_down <= r_pend_down | w_set_down;
         r_pend_in   <= r_pend_in   | w_set_in;
         case (r_state)
            ST_AT_FLOOR: begin
               if (w_stop) begin
                  r_state      <= ST_OPEN;
                  r_door_open  <= 1'b1;
                  r_dir        <= w_eff_dir;
                  r_door_timer <= c_DOOR_LOAD;
                  // A new press on this edge wins over the clear.
                  r_pend_in    <= (r_pend_in   & ~w_here)     | w_set_in;
                  r_pend_up    <= (r_pend_up   & ~w_clr_up)   | w_set_up;
                  r_pend_down  <= (r_pend_down & ~w_clr_down) | w_set_down;
               end else if (w_eff_dir != c_DIR_STOP) begin
                  r_state        <= ST_MOVE;
                  r_travel_timer <= c_TRAVEL_LOAD;
               end else if (w_above) begin
                  r_dir          <= c_DIR_UP;
                  r_state        <= ST_MOVE;
                  r_travel_timer <= c_TRAVEL_LOAD;
               end else if (w_below) begin
                  r_dir          <= c_DIR_DOWN;
                  r_state        <= ST_MOVE;
                  r_travel_timer <= c_TRAVEL_LOAD;
               end else begin
                  r_dir <= c_DIR_STOP;
               end
            end
            ST_OPEN: begin
               if (w_hold) begin
                  r_door_timer <= c_DOOR_LOAD;
               end else if (r_door_timer <= c_DOOR_ONE) begin
                  r_door_timer <= '0;
                  r_door_open  <= 1'b0;
                  r_state      <= ST_AT_FLOOR;
               end else begin
                  r_door_timer <= r_door_timer - 1'b1;
               end
            end
            ST_MOVE: begin
               if (r_travel_timer <= c_TRAVEL_ONE) begin
                  if (!r_half) begin
                     r_half         <= 1'b1;
                     r_travel_timer <= c_TRAVEL_LOAD;
                  end else begin
                     r_half         <= 1'b0;
                     r_travel_timer <= '0;
                     r_state        <= ST_AT_FLOOR;
                     if (r_dir == c_DIR_UP && r_floor < 2'd2)
                        r_floor <= r_floor + 1'b1;
                     else if (r_dir == c_DIR_DOWN && r_floor > 2'd0)
                        r_floor <= r_floor - 1'b1;
                  end
               end else begin
                  r_travel_timer <= r_travel_timer - 1'b1;
               end
            end
            default: r_state <= ST_AT_FLOOR;
         endcase
      end
   end

   assign floor        = r_floor;
   assign half         = r_half;
   assign door_open    = r_door_open;
   assign dir          = r_dir;
   assign pending_up   = r_pend_up;
   assign pending_down = r_pend_down;
   assign pending_in   = r_pend_in;
   assign busy         = (r_state != ST_AT_FLOOR) || (|w_req);

endmodule
`default_nettype wire

// File: tb/tb_elevator_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_sequencer
// Purpose  : Directed self-checking bench for elevator_sequencer with
//            hand-computed cycle timelines (DOOR_CYCLES=4, TRAVEL_CYCLES=2).
//            E denotes the edge on which MOVE is first entered.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] button_up = 3'b000;
   logic [2:0] button_down = 3'b000;
   logic [2:0] button_in = 3'b000;
   logic [1:0] floor;
   logic       half;
   logic       door_open;
   logic [1:0] dir;
   logic [2:0] pending_up;
   logic [2:0] pending_down;
   logic [2:0] pending_in;
   logic       busy;

   int checks = 0;
   int errors = 0;

   elevator_sequencer #(.DOOR_CYCLES(4), .TRAVEL_CYCLES(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .button_up(button_up), .button_down(button_down), .button_in(button_in),
      .floor(floor), .half(half), .door_open(door_open), .dir(dir),
      .pending_up(pending_up), .pending_down(pending_down),
      .pending_in(pending_in), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Advance n rising edges; return 1 time unit after the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #3;
      checks++; if (floor !== 2'd0) begin errors++; $display("FAIL rst_floor got %0d exp 0", floor); end
      checks++; if ({half, door_open, dir} !== 4'b0000) begin errors++; $display("FAIL rst_half_door_dir got %b exp 0000", {half, door_open, dir}); end
      checks++; if ({pending_up, pending_down, pending_in} !== 9'd0) begin errors++; $display("FAIL rst_pending got %b exp 0", {pending_up, pending_down, pending_in}); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic test_single_call();
      button_in = 3'b100; tick(1); button_in = 3'b000;      // latch edge
      checks++; if (pending_in !== 3'b100) begin errors++; $display("FAIL t1_latch got %b exp 100", pending_in); end
      checks++; if (dir !== 2'b00) begin errors++; $display("FAIL t1_dir_before got %b exp 00", dir); end
      tick(1);                                               // E
      checks++; if (dir !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL t1_move got dir=%b busy=%b exp 01/1", dir, busy); end
      tick(2);                                               // E+2
      checks++; if (half !== 1'b1 || floor !== 2'd0) begin errors++; $display("FAIL t1_half got half=%b floor=%0d exp 1/0", half, floor); end
      tick(2);                                               // E+4
      checks++; if (floor !== 2'd1 || half !== 1'b0) begin errors++; $display("FAIL t1_floor1 got floor=%0d half=%b exp 1/0", floor, half); end
      tick(5);                                               // E+9
      checks++; if (floor !== 2'd2 || door_open !== 1'b0) begin errors++; $display("FAIL t1_floor2 got floor=%0d door=%b exp 2/0", floor, door_open); end
      tick(1);                                               // E+10
      checks++; if (door_open !== 1'b1 || pending_in !== 3'b000 || dir !== 2'b00) begin errors++; $display("FAIL t1_open got door=%b pin=%b dir=%b exp 1/000/00", door_open, pending_in, dir); end
      tick(3);                                               // E+13
      checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL t1_dwell got %b exp 1", door_open); end
      tick(1);                                               // E+14
      checks++; if (door_open !== 1'b0 || busy !== 1'b0 || dir !== 2'b00) begin errors++; $display("FAIL t1_idle got door=%b busy=%b dir=%b exp 0/0/00", door_open, busy, dir); end
   endtask

   task automatic test_hall_call_here();
      do_reset();
      button_up = 3'b001; tick(1); button_up = 3'b000;
      checks++; if (pending_up !== 3'b001 || door_open !== 1'b0) begin errors++; $display("FAIL t2_latch got pup=%b door=%b exp 001/0", pending_up, door_open); end
      tick(1);
      checks++; if (door_open !== 1'b1 || floor !== 2'd0 || pending_up !== 3'b000) begin errors++; $display("FAIL t2_open got door=%b floor=%0d pup=%b exp 1/0/000", door_open, floor, pending_up); end
      tick(4);
      checks++; if (door_open !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t2_close got door=%b busy=%b exp 0/0", door_open, busy); end
   endtask

   // Leaves the car at floor 1 with the door freshly opened and dir=00.
   task automatic test_reverse();
      do_reset();
      button_in = 3'b100; tick(1); button_in = 3'b000;
      tick(1);                                               // E
      tick(2);                                               // E+2
      checks++; if (half !== 1'b1 || dir !== 2'b01) begin errors++; $display("FAIL t3_half got half=%b dir=%b exp 1/01", half, dir); end
      button_down = 3'b010; tick(1); button_down = 3'b000;   // E+3
      checks++; if (pending_down !== 3'b010) begin errors++; $display("FAIL t3_latch got %b exp 010", pending_down); end
      tick(2);                                               // E+5
      checks++; if (floor !== 2'd1 || door_open !== 1'b0 || dir !== 2'b01 || pending_down !== 3'b010) begin errors++; $display("FAIL t3_pass1 got floor=%0d door=%b dir=%b pdn=%b exp 1/0/01/010", floor, door_open, dir, pending_down); end
      tick(5);                                               // E+10
      checks++; if (floor !== 2'd2 || door_open !== 1'b1 || pending_in !== 3'b000 || pending_down !== 3'b010) begin errors++; $display("FAIL t3_top got floor=%0d door=%b pin=%b pdn=%b exp 2/1/000/010", floor, door_open, pending_in, pending_down); end
      tick(5);                                               // E+15
      checks++; if (dir !== 2'b10 || door_open !== 1'b0) begin errors++; $display("FAIL t3_reverse got dir=%b door=%b exp 10/0", dir, door_open); end
      tick(5);                                               // E+20
      checks++; if (floor !== 2'd1 || door_open !== 1'b1 || pending_down !== 3'b000 || dir !== 2'b00) begin errors++; $display("FAIL t3_stop1 got floor=%0d door=%b pdn=%b dir=%b exp 1/1/000/00", floor, door_open, pending_down, dir); end
   endtask

   task automatic test_door_hold();
      button_in = 3'b010;
      for (int i = 0; i < 3; i++) begin                      // E+21..E+23
         tick(1);
         checks++; if (door_open !== 1'b1 || pending_in !== 3'b000) begin errors++; $display("FAIL t4_hold%0d got door=%b pin=%b exp 1/000", i, door_open, pending_in); end
      end
      button_in = 3'b000;
      tick(3);                                               // E+26
      checks++; if (door_open !== 1'b1 || pending_in !== 3'b000) begin errors++; $display("FAIL t4_extended got door=%b pin=%b exp 1/000", door_open, pending_in); end
      tick(1);                                               // E+27
      checks++; if (door_open !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t4_close got door=%b busy=%b exp 0/0", door_open, busy); end
   endtask

   task automatic test_reset_mid_move();
      do_reset();
      button_in = 3'b100; tick(1); button_in = 3'b000;
      tick(8);                                               // E+7
      checks++; if (floor !== 2'd1 || half !== 1'b1 || dir !== 2'b01) begin errors++; $display("FAIL t5_pos got floor=%0d half=%b dir=%b exp 1/1/01", floor, half, dir); end
      reset_n = 1'b0;
      #1;
      checks++; if ({floor, half, dir, door_open} !== 6'd0) begin errors++; $display("FAIL t5_async got floor=%0d half=%b dir=%b door=%b exp 0", floor, half, dir, door_open); end
      checks++; if ({pending_up, pending_down, pending_in} !== 9'd0 || busy !== 1'b0) begin errors++; $display("FAIL t5_pending got %b busy=%b exp 0/0", {pending_up, pending_down, pending_in}, busy); end
      tick(1);
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic test_ignored_buttons();
      button_up = 3'b100; button_down = 3'b001;
      tick(3);
      button_up = 3'b000; button_down = 3'b000;
      checks++; if (pending_up !== 3'b000 || pending_down !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL t6_pending got pup=%b pdn=%b busy=%b exp 000/000/0", pending_up, pending_down, busy); end
      tick(4);
      checks++; if (floor !== 2'd0 || dir !== 2'b00 || door_open !== 1'b0 || half !== 1'b0) begin errors++; $display("FAIL t6_still got floor=%0d dir=%b door=%b half=%b exp 0/00/0/0", floor, dir, door_open, half); end
   endtask

   initial begin
      test_reset();
      test_single_call();
      test_hall_call_here();
      test_reverse();
      test_door_hold();
      test_reset_mid_move();
      test_ignored_buttons();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
